// File: rtl/mux_wr_arbiter.sv
// Round-robin write-back arbiter for seven sources sharing one register-bank
// write port. A grant opens a write window of WR_CYCLES cycles during which
// mux_sel/wr_addr are frozen. The next winner is chosen on the last window
// cycle, so back-to-back windows have no idle bubble.
module mux_wr_arbiter #(
  parameter int unsigned WR_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  req,
  input  logic [34:0] wr_addr_i,
  output logic [6:0]  gnt,
  output logic [2:0]  mux_sel,
  output logic        reg_write,
  output logic [4:0]  wr_addr,
  output logic        busy
);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;      // window cycles left after the current one
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [6:0]  gnt_q, gnt_d;
  logic [2:0]  sel_q, sel_d;
  logic [4:0]  addr_q, addr_d;
  logic        rw_q, rw_d;

  // Slot 7 is padding so an 8-entry index never runs off the end.
  logic [7:0][4:0] src_addr;
  assign src_addr = {5'd0, wr_addr_i};

  logic        win_found;
  logic [2:0]  win_idx;
  logic [3:0]  scan_idx;

  // Pick the first requester at or above rr_ptr, wrapping 6 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    scan_idx  = 4'd0;
    for (int j = 0; j < 7; j++) begin
      scan_idx = {1'b0, rr_ptr_q} + 4'(j);
      if (scan_idx >= 4'd7) begin
        scan_idx = scan_idx - 4'd7;
      end
      if (!win_found && req[scan_idx[2:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[2:0];
      end
    end
  end

  // Next-state: hold the window, or arbitrate when idle / on the final window cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = 7'd0;
    sel_d    = sel_q;
    addr_d   = addr_q;
    rw_d     = rw_q;

    unique case (state_q)
      StIdle:  rw_d = 1'b0;
      StWrite: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else if (!win_found) begin
          state_d = StIdle;
          rw_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (win_found && (state_q == StIdle || cnt_q == 2'd0)) begin
      state_d  = StWrite;
      cnt_d    = 2'(WR_CYCLES - 1);
      gnt_d    = 7'd1 << win_idx;
      sel_d    = win_idx;
      addr_d   = src_addr[win_idx];
      // Register 0 is hardwired; the window still runs but never writes.
      rw_d     = |src_addr[win_idx];
      rr_ptr_d = (win_idx == 3'd6) ? 3'd0 : win_idx + 3'd1;
    end
  end

  // State and output registers; reset aborts any window in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 2'd0;
      rr_ptr_q <= 3'd0;
      gnt_q    <= 7'd0;
      sel_q    <= 3'd0;
      addr_q   <= 5'd0;
      rw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
    end
  end

  assign gnt       = gnt_q;
  assign mux_sel   = sel_q;
  assign wr_addr   = addr_q;
  assign reg_write = rw_q;
  assign busy      = (state_q == StWrite);

endmodule

// File: tb/tb_mux_wr_arbiter.sv
// Bench for mux_wr_arbiter: three instances (WR_CYCLES 1, 2, 3) share one
// stimulus stream; a reference model predicts each instance's outputs after
// every clock edge, the driver queues them and a monitor compares.
module tb_mux_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [6:0]  req;
  logic [34:0] wr_addr_i;

  logic [6:0] gnt_w       [3];
  logic [2:0] mux_sel_w   [3];
  logic       reg_write_w [3];
  logic [4:0] wr_addr_w   [3];
  logic       busy_w      [3];

  mux_wr_arbiter #(.WR_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .req(req), .wr_addr_i(wr_addr_i),
    .gnt(gnt_w[0]), .mux_sel(mux_sel_w[0]), .reg_write(reg_write_w[0]),
    .wr_addr(wr_addr_w[0]), .busy(busy_w[0])
  );
  mux_wr_arbiter #(.WR_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .req(req), .wr_addr_i(wr_addr_i),
    .gnt(gnt_w[1]), .mux_sel(mux_sel_w[1]), .reg_write(reg_write_w[1]),
    .wr_addr(wr_addr_w[1]), .busy(busy_w[1])
  );
  mux_wr_arbiter #(.WR_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .req(req), .wr_addr_i(wr_addr_i),
    .gnt(gnt_w[2]), .mux_sel(mux_sel_w[2]), .reg_write(reg_write_w[2]),
    .wr_addr(wr_addr_w[2]), .busy(busy_w[2])
  );

  typedef struct packed {
    logic [2:0][6:0] gnt;
    logic [2:0][2:0] sel;
    logic [2:0][4:0] addr;
    logic [2:0]      rw;
    logic [2:0]      busy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: rem = window cycles still to run including the current one.
  int         wr_cycles [3] = '{1, 2, 3};
  int         rem       [3];
  int         ptr       [3];
  logic [6:0] m_gnt     [3];
  logic [2:0] m_sel     [3];
  logic [4:0] m_addr    [3];
  logic       m_rw      [3];

  function automatic void chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (WR_CYCLES=%0d) at %0t: got %0h, expected %0h",
               nm, k + 1, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0; ptr[k] = 0; m_gnt[k] = 7'd0;
      m_sel[k] = 3'd0; m_addr[k] = 5'd0; m_rw[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(logic [6:0] r, logic [34:0] a);
    for (int k = 0; k < 3; k++) begin
      if (rem[k] >= 2) begin
        rem[k]--;
        m_gnt[k] = 7'd0;
      end else begin
        bit found = 1'b0;
        int win = 0;
        for (int j = 0; j < 7; j++) begin
          int i = (ptr[k] + j) % 7;
          if (!found && r[i]) begin
            found = 1'b1;
            win = i;
          end
        end
        if (found) begin
          m_gnt[k]  = 7'd1 << win;
          m_sel[k]  = 3'(win);
          m_addr[k] = a[5*win +: 5];
          m_rw[k]   = (m_addr[k] != 5'd0);
          rem[k]    = wr_cycles[k];
          ptr[k]    = (win + 1) % 7;
        end else begin
          rem[k]   = 0;
          m_gnt[k] = 7'd0;
          m_rw[k]  = 1'b0;
        end
      end
    end
  endfunction

  function automatic exp_t model_pack();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e.gnt[k]  = m_gnt[k];
      e.sel[k]  = m_sel[k];
      e.addr[k] = m_addr[k];
      e.rw[k]   = m_rw[k];
      e.busy[k] = (rem[k] > 0);
    end
    return e;
  endfunction

  task automatic check_zero(string nm);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_gnt"}, k, 32'(gnt_w[k]), 32'd0);
      chk({nm, "_sel"}, k, 32'(mux_sel_w[k]), 32'd0);
      chk({nm, "_addr"}, k, 32'(wr_addr_w[k]), 32'd0);
      chk({nm, "_rw"}, k, 32'(reg_write_w[k]), 32'd0);
      chk({nm, "_busy"}, k, 32'(busy_w[k]), 32'd0);
    end
  endtask

  // One clock of stimulus, applied at the falling edge; the expectation for
  // the following rising edge is queued for the monitor.
  task automatic cycle(logic rst_v, logic [6:0] r, logic [34:0] a);
    @(negedge clk);
    reset = rst_v;
    req = r;
    wr_addr_i = a;
    if (!rst_v) begin
      model_reset();
      #1 check_zero("async_reset");
    end else begin
      model_step(r, a);
    end
    q.push_back(model_pack());
  endtask

  // Monitor: compare every instance shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < 3; k++) begin
          chk("gnt", k, 32'(gnt_w[k]), 32'(e.gnt[k]));
          chk("mux_sel", k, 32'(mux_sel_w[k]), 32'(e.sel[k]));
          chk("wr_addr", k, 32'(wr_addr_w[k]), 32'(e.addr[k]));
          chk("reg_write", k, 32'(reg_write_w[k]), 32'(e.rw[k]));
          chk("busy", k, 32'(busy_w[k]), 32'(e.busy[k]));
        end
      end
    end
  end

  initial begin
    logic [34:0] a;
    logic [6:0]  r;
    reset = 1'b0;
    req = 7'd0;
    wr_addr_i = 35'd0;
    model_reset();
    #1 check_zero("reset_state");
    cycle(1'b0, 7'd0, 35'd0);
    cycle(1'b1, 7'd0, 35'd0);

    // Single request from source 2, address 5.
    a = 35'd0;
    a[14:10] = 5'd5;
    cycle(1'b1, 7'b0000100, a);
    repeat (4) cycle(1'b1, 7'd0, a);

    // All sources requesting, all addresses nonzero.
    a = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    repeat (8) cycle(1'b1, 7'h7f, a);
    repeat (4) cycle(1'b1, 7'd0, a);

    // Source 4 (addr 9), then source 1 raised mid-window.
    a = 35'd0;
    a[24:20] = 5'd9;
    a[9:5] = 5'd12;
    cycle(1'b1, 7'b0010000, a);
    cycle(1'b1, 7'd0, a);
    repeat (3) cycle(1'b1, 7'b0000010, a);
    repeat (4) cycle(1'b1, 7'd0, a);

    // Source 6 targeting register 0: window runs, no write.
    a = 35'h7_ffff_ffff;
    a[34:30] = 5'd0;
    cycle(1'b1, 7'b1000000, a);
    repeat (4) cycle(1'b1, 7'd0, a);

    // Reset in the first window cycle, then sources 0 and 1 compete.
    a = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    cycle(1'b1, 7'b0000100, a);
    cycle(1'b0, 7'd0, a);
    cycle(1'b1, 7'b0000011, a);
    repeat (5) cycle(1'b1, 7'd0, a);

    // Randomized traffic with occasional zero addresses and resets.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 7; i++) begin
        a[5*i +: 5] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      end
      r = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'($urandom & $urandom & $urandom);
      cycle(($urandom_range(0, 99) != 0), r, a);
    end

    repeat (6) cycle(1'b1, 7'd0, 35'd0);
    repeat (3) @(posedge clk);
    #2 chk("queue_drained", 0, 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
